// File: rtl/usr_pkg.sv
// Shared definitions for the transmit controller and the universal shift register it drives.
// Mode codes follow the register's s input: hold, shift right, shift left, parallel load.
package usr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  function automatic logic [1:0] shift_code(input bit dir);
    return dir ? S_SHL : S_SHR;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Mod-N counter with synchronous clear and count enable; tracks the bit position within a frame.
module bit_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == W'(N - 1)) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/shift_tx_ctrl.sv
// Parallel-to-serial transmit controller that sequences an external universal shift register.
// The register updates on the falling edge, so ser_out samples its tap on the following rising edge.
module shift_tx_ctrl
  import usr_pkg::*;
#(
  parameter int   N    = 4,
  parameter bit   DIR  = 1'b0,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         abort,
  output logic [1:0]   s,
  output logic [N-1:0] I,
  output logic         MSB_in,
  output logic         LSB_in,
  input  logic [N-1:0] q,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_t        state;
  logic [CW-1:0] counter;
  logic          last_bit;
  logic          accept;
  logic          q_tap;

  bit_counter #(
    .N (N),
    .W (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != ST_SHIFT),
    .enable  (state == ST_SHIFT),
    .count   (counter)
  );

  assign last_bit  = (counter == CW'(N - 1));
  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = in_valid & in_ready & ~abort;
  assign q_tap     = DIR ? q[N-1] : q[0];
  assign busy      = (state == ST_LOAD) || (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign ser_valid = (state == ST_SHIFT);
  assign MSB_in    = FILL;
  assign LSB_in    = FILL;

  always_comb begin
    s = S_HOLD;
    case (state)
      ST_LOAD:  s = S_LOAD;
      ST_SHIFT: s = shift_code(DIR);
      default:  s = S_HOLD;
    endcase
  end

  // ser_out only moves on edges that lead into SHIFT, so it tracks the bit being presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      I       <= '0;
      ser_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state <= ST_LOAD;
            I     <= in_data;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_SHIFT;
            ser_out <= q_tap;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (last_bit) begin
            state <= ST_DONE;
          end else begin
            ser_out <= q_tap;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench: two controllers (LSB-first fill 0, MSB-first fill 1) each driving a behavioural shift register.
// Expected values come from a frame-timeline model: 1 LOAD, N SHIFT, 1 DONE cycle per word.
module tb_shift_tx_ctrl;

  localparam int N = 4;

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic         in_valid = 1'b0;
  logic         abort    = 1'b0;
  logic [N-1:0] in_data  = '0;

  logic         in_ready_a, msb_a, lsb_a, ser_out_a, ser_valid_a, busy_a, done_a;
  logic [1:0]   s_a;
  logic [N-1:0] i_a;
  logic [N-1:0] q_a = '0;
  logic         in_ready_b, msb_b, lsb_b, ser_out_b, ser_valid_b, busy_b, done_b;
  logic [1:0]   s_b;
  logic [N-1:0] i_b;
  logic [N-1:0] q_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_tx_ctrl #(.N(N), .DIR(1'b0), .FILL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .abort(abort), .s(s_a), .I(i_a), .MSB_in(msb_a),
    .LSB_in(lsb_a), .q(q_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a),
    .busy(busy_a), .done(done_a)
  );

  shift_tx_ctrl #(.N(N), .DIR(1'b1), .FILL(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .abort(abort), .s(s_b), .I(i_b), .MSB_in(msb_b),
    .LSB_in(lsb_b), .q(q_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .busy(busy_b), .done(done_b)
  );

  // Universal shift registers, updated on the falling edge.
  always @(negedge clk) begin
    case (s_a)
      2'b01:   q_a <= {msb_a, q_a[N-1:1]};
      2'b10:   q_a <= {q_a[N-2:0], lsb_a};
      2'b11:   q_a <= i_a;
      default: q_a <= q_a;
    endcase
    case (s_b)
      2'b01:   q_b <= {msb_b, q_b[N-1:1]};
      2'b10:   q_b <= {q_b[N-2:0], lsb_b};
      2'b11:   q_b <= i_b;
      default: q_b <= q_b;
    endcase
  end

  function automatic logic tx_bit(input logic [N-1:0] w, input int k, input bit msb_first);
    return msb_first ? w[N-1-k] : w[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    repeat (2) @(posedge clk);
    #1;
    got = 16'({s_a, in_ready_a, ser_valid_a, done_a, busy_a, ser_out_a});
    exp = 16'({2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_ctrl_a got=%h exp=%h", got, exp); end
    got = 16'({s_b, in_ready_b, ser_valid_b, done_b, busy_b, ser_out_b});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_ctrl_b got=%h exp=%h", got, exp); end
    got = 16'({i_a, i_b});
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL reset_I got=%h exp=0000", got); end
    reset_n = 1'b1;
    step();
    got = 16'({s_a, s_b, in_ready_a, in_ready_b, busy_a, busy_b});
    exp = 16'({2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
  endtask

  // directed=1 sends 1011 then 0110 back-to-back; otherwise random words and random gaps.
  task automatic test_stream(input int frames, input bit directed);
    logic [N-1:0] cur, nxt;
    logic [15:0]  got, exp;
    int           gap;
    bit           last;
    cur = directed ? 4'b1011 : 4'($urandom);
    in_valid = 1'b1; in_data = cur; abort = 1'b0;
    step();
    for (int f = 0; f < frames; f++) begin
      got = 16'({s_a, busy_a, ser_valid_a, done_a, in_ready_a, i_a});
      exp = 16'({2'b11, 1'b1, 1'b0, 1'b0, 1'b0, cur});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL load_a f=%0d got=%h exp=%h", f, got, exp); end
      got = 16'({s_b, busy_b, ser_valid_b, done_b, in_ready_b, i_b});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL load_b f=%0d got=%h exp=%h", f, got, exp); end
      in_valid = 1'($urandom); in_data = 4'($urandom);
      step();
      for (int k = 0; k < N; k++) begin
        got = 16'({s_a, ser_valid_a, ser_out_a, done_a, i_a});
        exp = 16'({2'b01, 1'b1, tx_bit(cur, k, 1'b0), 1'b0, cur});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL shift_a f=%0d k=%0d got=%h exp=%h", f, k, got, exp); end
        got = 16'({s_b, ser_valid_b, ser_out_b, done_b, i_b});
        exp = 16'({2'b10, 1'b1, tx_bit(cur, k, 1'b1), 1'b0, cur});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL shift_b f=%0d k=%0d got=%h exp=%h", f, k, got, exp); end
        in_valid = 1'($urandom); in_data = 4'($urandom);
        step();
      end
      last = (f == frames - 1);
      gap  = last ? 1 : (directed ? 0 : int'($urandom_range(0, 2)));
      nxt  = directed ? 4'b0110 : 4'($urandom);
      got = 16'({s_a, done_a, busy_a, in_ready_a, ser_valid_a, q_a});
      exp = 16'({2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL done_a f=%0d got=%h exp=%h", f, got, exp); end
      got = 16'({s_b, done_b, busy_b, in_ready_b, ser_valid_b, q_b});
      exp = 16'({2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL done_b f=%0d got=%h exp=%h", f, got, exp); end
      in_valid = (gap == 0); in_data = nxt;
      step();
      for (int g = 0; g < gap; g++) begin
        got = 16'({s_a, s_b, done_a, done_b, busy_a, busy_b, in_ready_a, in_ready_b, ser_valid_a, ser_valid_b});
        exp = 16'({2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL idle f=%0d g=%0d got=%h exp=%h", f, g, got, exp); end
        in_valid = (g == gap - 1) && !last; in_data = nxt;
        step();
      end
      cur = nxt;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [N-1:0] d;
    logic [15:0]  got, exp;
    d = 4'($urandom);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    // Two shifts happened before the abort took effect; the register then holds.
    got = 16'({s_a, ser_valid_a, done_a, busy_a, in_ready_a, q_a});
    exp = 16'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'(d >> 2)});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_shift_a got=%h exp=%h", got, exp); end
    got = 16'({s_b, ser_valid_b, done_b, busy_b, in_ready_b, q_b});
    exp = 16'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'({d, 2'b11})});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_shift_b got=%h exp=%h", got, exp); end
    in_valid = 1'b1; in_data = 4'($urandom);
    step();
    got = 16'({s_a, s_b, busy_a, busy_b, done_a, done_b});
    exp = 16'({2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_idle_block got=%h exp=%h", got, exp); end
    abort = 1'b0; in_valid = 1'b0;
    step();
    got = 16'({busy_a, busy_b, done_a, done_b, q_a, q_b});
    exp = 16'({4'b0000, 4'(d >> 2), 4'({d, 2'b11})});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_no_done got=%h exp=%h", got, exp); end
    in_valid = 1'b1; in_data = 4'($urandom);
    step();
    in_valid = 1'b0;
    repeat (N + 1) step();
    got = 16'({done_a, done_b});
    checks++;
    if (got !== 16'h0003) begin errors++; $display("FAIL abort_done_pulse got=%h exp=0003", got); end
    abort = 1'b1; in_valid = 1'b1;
    step();
    got = 16'({s_a, s_b, busy_a, busy_b, done_a, done_b});
    exp = 16'({2'b00, 2'b00, 4'b0000});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL abort_done_block got=%h exp=%h", got, exp); end
    abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] got, exp;
    in_valid = 1'b1; in_data = 4'($urandom);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    got = 16'({s_a, ser_valid_a, busy_a, done_a, in_ready_a, ser_out_a, i_a});
    exp = 16'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_a got=%h exp=%h", got, exp); end
    got = 16'({s_b, ser_valid_b, busy_b, done_b, in_ready_b, ser_out_b, i_b});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL async_reset_b got=%h exp=%h", got, exp); end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < N + 2; c++) begin
      step();
      got = 16'({done_a, done_b, busy_a, busy_b});
      checks++;
      if (got !== 16'h0000) begin errors++; $display("FAIL post_reset_done c=%0d got=%h exp=0000", c, got); end
    end
  endtask

  initial begin
    test_reset();
    test_stream(2, 1'b1);
    test_stream(12, 1'b0);
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
